// File: rtl/fir_l3_pkg.sv
// fir_l3_pkg: shared types for the 3-parallel FIR frame sequencer.
// Holds the sequencer state enum, the per-frame tag carried alongside the
// filter pipeline, and the lane count of a frame.
package fir_l3_pkg;

  // Number of samples packed into one filter frame.
  localparam int LANES = 3;

  // Width of one packed tag entry.
  localparam int TAG_W = 3;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Frame tag: number of real lanes (0 = flush frame) and end-of-burst mark.
  typedef struct packed {
    logic [1:0] lane_cnt;
    logic       last;
  } tag_t;

endpackage

// File: rtl/fir_l3_out_fifo.sv
// fir_l3_out_fifo: synchronous result FIFO holding one filter result frame
// (three lanes plus tag) per entry. Exposes the occupancy count so the
// sequencer can throttle frame issue before the FIFO can overflow.
// Writes while full and reads while empty are ignored.
module fir_l3_out_fifo #(
  parameter int WIDTH = 195,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic             wr_fire_s;
  logic             rd_fire_s;

  assign empty     = (count == CW'(0));
  assign wr_fire_s = wr_en && (count != CW'(DEPTH));
  assign rd_fire_s = rd_en && !empty;
  assign rd_data   = mem_r[rd_ptr_r];

  // Storage array: written on an accepted push, no reset needed for data.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy count; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count    <= CW'(0);
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_l3_frame_sequencer.sv
// fir_l3_frame_sequencer: packs a serial sample stream into 3-lane frames for
// the reduced-complexity parallel FIR, steps the filter with fir_en, tracks
// each frame through the filter latency with a tag pipeline, buffers results
// in fir_l3_out_fifo and re-serialises them with valid/ready backpressure.
// A burst ending in s_last is followed by FLUSH_LEN zero frames whose results
// are dropped.
// Optional build macro FIR_SEQ_STATS_EN adds stat_frames / stat_stalls.
module fir_l3_frame_sequencer
  import fir_l3_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 64,
  parameter int PIPE_LATENCY   = 8,
  parameter int FLUSH_LEN      = 40,
  parameter int OUT_FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic signed [DATA_IN_WIDTH-1:0]  s_data,
  input  logic                             s_last,
  output logic                             fir_en,
  output logic signed [DATA_IN_WIDTH-1:0]  frm_data_1,
  output logic signed [DATA_IN_WIDTH-1:0]  frm_data_2,
  output logic signed [DATA_IN_WIDTH-1:0]  frm_data_3,
  input  logic signed [DATA_OUT_WIDTH-1:0] fir_out_1,
  input  logic signed [DATA_OUT_WIDTH-1:0] fir_out_2,
  input  logic signed [DATA_OUT_WIDTH-1:0] fir_out_3,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic signed [DATA_OUT_WIDTH-1:0] m_data,
  output logic                             m_last,
  output logic                             busy
`ifdef FIR_SEQ_STATS_EN
  ,
  output logic [31:0]                      stat_frames,
  output logic [31:0]                      stat_stalls
`endif
);

  localparam int FIFO_W = LANES * DATA_OUT_WIDTH + TAG_W;
  localparam int CNT_W  = $clog2(OUT_FIFO_DEPTH) + 1;
  localparam int FL_W   = $clog2(FLUSH_LEN + 1);

  state_t                    state_r;
  logic [1:0]                lane_idx_r;
  tag_t                      issue_tag_r;
  logic [FL_W-1:0]           flush_cnt_r;
  tag_t                      tags_r [PIPE_LATENCY];
  tag_t                      tail_tag_s;
  logic                      tag_any_s;

  logic                      accept_s;
  logic                      pending_wr_s;
  logic [CNT_W:0]            fill_after_s;
  logic                      room_s;

  logic                      wr_en_s;
  logic [FIFO_W-1:0]         wr_data_s;
  logic                      rd_en_s;
  logic [FIFO_W-1:0]         rd_data_s;
  logic [CNT_W-1:0]          count_s;
  logic                      empty_s;

  tag_t                      pop_tag_s;
  logic [DATA_OUT_WIDTH-1:0] pop_lane_s [LANES];
  logic [DATA_OUT_WIDTH-1:0] ser_lanes_r [LANES];
  tag_t                      ser_tag_r;
  logic [1:0]                ser_idx_r;
  logic                      ser_active_r;
  logic                      advance_s;

  assign accept_s   = s_valid && s_ready;
  assign tail_tag_s = tags_r[PIPE_LATENCY-1];

  // A result frame leaves the filter on every fir_en; keep only real frames.
  assign wr_en_s   = fir_en && (tail_tag_s.lane_cnt != 2'd0);
  assign wr_data_s = {fir_out_3, fir_out_2, fir_out_1, tail_tag_s};

  // Room is judged on the occupancy after this edge's write and ignores any
  // pop in the same cycle, so an issued frame always has a slot waiting.
  assign pending_wr_s = wr_en_s;
  assign fill_after_s = {1'b0, count_s} + {{CNT_W{1'b0}}, pending_wr_s};
  assign room_s       = (fill_after_s < (CNT_W + 1)'(OUT_FIFO_DEPTH));

  // Serialiser may load a new word when the output register is free or draining.
  assign advance_s = !m_valid || m_ready;
  assign rd_en_s   = advance_s && !ser_active_r && !empty_s;

  fir_l3_out_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en_s),
    .wr_data (wr_data_s),
    .rd_en   (rd_en_s),
    .rd_data (rd_data_s),
    .count   (count_s),
    .empty   (empty_s)
  );

  // Split the FIFO head entry into its tag and lanes, and flag live tags.
  always_comb begin
    pop_tag_s = tag_t'(rd_data_s[TAG_W-1:0]);
    for (int i = 0; i < LANES; i++) begin
      pop_lane_s[i] = rd_data_s[TAG_W + i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
    end
    tag_any_s = 1'b0;
    for (int i = 0; i < PIPE_LATENCY; i++) begin
      if (tags_r[i].lane_cnt != 2'd0) begin
        tag_any_s = 1'b1;
      end else begin
        tag_any_s = tag_any_s;
      end
    end
  end

  // Frame FSM: fill lanes, issue one enable per frame when room, flush zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= FILL;
      lane_idx_r  <= 2'd0;
      issue_tag_r <= '0;
      flush_cnt_r <= FL_W'(0);
      s_ready     <= 1'b0;
      fir_en      <= 1'b0;
      frm_data_1  <= '0;
      frm_data_2  <= '0;
      frm_data_3  <= '0;
    end else begin
      case (state_r)
        FILL: begin
          fir_en <= 1'b0;
          if (accept_s) begin
            case (lane_idx_r)
              2'd0: begin
                frm_data_1 <= s_data;
                frm_data_2 <= '0;
                frm_data_3 <= '0;
              end
              2'd1:    frm_data_2 <= s_data;
              default: frm_data_3 <= s_data;
            endcase
            if ((lane_idx_r == 2'd2) || s_last) begin
              state_r     <= ISSUE;
              s_ready     <= 1'b0;
              lane_idx_r  <= 2'd0;
              issue_tag_r <= '{lane_cnt: lane_idx_r + 2'd1, last: s_last};
              fir_en      <= room_s;
            end else begin
              lane_idx_r <= lane_idx_r + 2'd1;
              s_ready    <= 1'b1;
            end
          end else begin
            s_ready <= 1'b1;
          end
        end
        ISSUE: begin
          if (fir_en) begin
            if (issue_tag_r.last) begin
              state_r     <= FLUSH;
              flush_cnt_r <= FL_W'(0);
              issue_tag_r <= '0;
              frm_data_1  <= '0;
              frm_data_2  <= '0;
              frm_data_3  <= '0;
              fir_en      <= room_s;
            end else begin
              state_r <= FILL;
              s_ready <= 1'b1;
              fir_en  <= 1'b0;
            end
          end else begin
            fir_en <= room_s;
          end
        end
        FLUSH: begin
          if (fir_en) begin
            if (flush_cnt_r == FL_W'(FLUSH_LEN - 1)) begin
              state_r     <= FILL;
              flush_cnt_r <= FL_W'(0);
              s_ready     <= 1'b1;
              fir_en      <= 1'b0;
            end else begin
              flush_cnt_r <= flush_cnt_r + FL_W'(1);
              fir_en      <= room_s;
            end
          end else begin
            fir_en <= room_s;
          end
        end
        default: begin
          state_r <= FILL;
          s_ready <= 1'b0;
          fir_en  <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline mirrors the filter: it advances only when the filter does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tags_r[i] <= '0;
      end
    end else if (fir_en) begin
      tags_r[0] <= issue_tag_r;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tags_r[i] <= tags_r[i-1];
      end
    end
  end

  // Serialiser: present lanes 1..count of each popped frame one per handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      ser_tag_r    <= '0;
      ser_idx_r    <= 2'd0;
      ser_active_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        ser_lanes_r[i] <= '0;
      end
    end else if (advance_s) begin
      if (ser_active_r) begin
        m_valid <= 1'b1;
        case (ser_idx_r)
          2'd1:    m_data <= ser_lanes_r[1];
          default: m_data <= ser_lanes_r[2];
        endcase
        if (ser_idx_r == (ser_tag_r.lane_cnt - 2'd1)) begin
          m_last       <= ser_tag_r.last;
          ser_active_r <= 1'b0;
        end else begin
          m_last <= 1'b0;
        end
        ser_idx_r <= ser_idx_r + 2'd1;
      end else if (!empty_s) begin
        m_valid   <= 1'b1;
        m_data    <= pop_lane_s[0];
        ser_tag_r <= pop_tag_s;
        for (int i = 0; i < LANES; i++) begin
          ser_lanes_r[i] <= pop_lane_s[i];
        end
        if (pop_tag_s.lane_cnt == 2'd1) begin
          m_last       <= pop_tag_s.last;
          ser_active_r <= 1'b0;
        end else begin
          m_last       <= 1'b0;
          ser_active_r <= 1'b1;
          ser_idx_r    <= 2'd1;
        end
      end else begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

  // Busy while flushing or while any real frame is still in flight or queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_r == FLUSH) || tag_any_s || !empty_s || ser_active_r || m_valid;
    end
  end

`ifdef FIR_SEQ_STATS_EN
  // Count real frames issued and issue/flush cycles held off for lack of room.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_frames <= 32'd0;
      stat_stalls <= 32'd0;
    end else begin
      if ((state_r == ISSUE) && fir_en) begin
        stat_frames <= stat_frames + 32'd1;
      end
      if (((state_r == ISSUE) || (state_r == FLUSH)) && !fir_en) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fir_l3_frame_sequencer.sv
// Directed self-checking bench for fir_l3_frame_sequencer with an identity
// filter model of PIPE_LATENCY enables. Inputs change 1 time unit after the
// rising edge; outputs and handshakes are sampled on the falling edge.
module tb_fir_l3_frame_sequencer;

  logic               clk;
  logic               reset_n;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               s_last;
  logic               fir_en;
  logic signed [15:0] frm_data_1, frm_data_2, frm_data_3;
  logic signed [63:0] fir_out_1, fir_out_2, fir_out_3;
  logic               m_valid;
  logic               m_ready;
  logic signed [63:0] m_data;
  logic               m_last;
  logic               busy;
`ifdef FIR_SEQ_STATS_EN
  logic [31:0]        stat_frames;
  logic [31:0]        stat_stalls;
`endif

  fir_l3_frame_sequencer #(
    .DATA_IN_WIDTH (16), .DATA_OUT_WIDTH (64), .PIPE_LATENCY (8),
    .FLUSH_LEN (40), .OUT_FIFO_DEPTH (8)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data), .s_last (s_last),
    .fir_en (fir_en),
    .frm_data_1 (frm_data_1), .frm_data_2 (frm_data_2), .frm_data_3 (frm_data_3),
    .fir_out_1 (fir_out_1), .fir_out_2 (fir_out_2), .fir_out_3 (fir_out_3),
    .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_last (m_last),
    .busy (busy)
`ifdef FIR_SEQ_STATS_EN
    , .stat_frames (stat_frames), .stat_stalls (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Identity filter: a frame issued on one enable reappears on the 8th enable after.
  logic [47:0] pipe [8];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) pipe[i] <= 48'd0;
    end else if (fir_en) begin
      pipe[0] <= {frm_data_3, frm_data_2, frm_data_1};
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fir_out_1 = {{48{pipe[7][15]}}, pipe[7][15:0]};
  assign fir_out_2 = {{48{pipe[7][31]}}, pipe[7][31:16]};
  assign fir_out_3 = {{48{pipe[7][47]}}, pipe[7][47:32]};

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          ready_mode   = 0;   // 0: always ready, 1: never ready, 2: toggle
  logic [15:0] src_d_q [$];
  logic        src_l_q [$];
  logic [63:0] out_d_q [$];
  logic        out_l_q [$];
  logic [47:0] frm_q [$];
  int          acc_cnt, en_cnt, stab_err;
  logic        busy_seen, hold_pending, held_l;
  logic [63:0] held_d;

  task automatic clear_mon();
    src_d_q.delete(); src_l_q.delete(); out_d_q.delete(); out_l_q.delete(); frm_q.delete();
    acc_cnt = 0; en_cnt = 0; stab_err = 0; busy_seen = 1'b0; hold_pending = 1'b0;
    held_d = 64'd0; held_l = 1'b0;
  endtask

  task automatic push_src(input logic [15:0] d, input logic l);
    src_d_q.push_back(d);
    src_l_q.push_back(l);
  endtask

  // One clock: drive inputs, observe at the falling edge, return at posedge+1.
  task automatic step_cycle();
    s_valid = (src_d_q.size() > 0);
    s_data  = s_valid ? src_d_q[0] : 16'd0;
    s_last  = s_valid ? src_l_q[0] : 1'b0;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'b0;
      default: m_ready = ~m_ready;
    endcase
    @(negedge clk);
    if (s_valid && s_ready) begin
      void'(src_d_q.pop_front());
      void'(src_l_q.pop_front());
      acc_cnt++;
    end
    if (fir_en) begin
      en_cnt++;
      frm_q.push_back({frm_data_3, frm_data_2, frm_data_1});
    end
    if (busy) busy_seen = 1'b1;
    if (hold_pending && (!m_valid || m_data !== held_d || m_last !== held_l)) stab_err++;
    hold_pending = m_valid && !m_ready;
    held_d = m_data;
    held_l = m_last;
    if (m_valid && m_ready) begin
      out_d_q.push_back(m_data);
      out_l_q.push_back(m_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  // Run until n outputs seen and busy low (bounded), then a few idle cycles.
  task automatic run_until(input string name, input int n, input int bound);
    int k;
    k = 0;
    while (!(out_d_q.size() >= n && !busy) && k < bound) begin
      step_cycle();
      k++;
    end
    tests_run++;
    if (k >= bound) begin
      tests_failed++;
      $display("FAIL %s_timeout: outputs=%0d busy=%0b required outputs=%0d busy=0", name, out_d_q.size(), busy, n);
    end
    run_cycles(20);
  endtask

  // Tally outputs that differ from base, base+1, ... and where m_last appeared.
  task automatic scan_seq(input int base, output int bad, output int last_cnt, output int last_pos);
    bad = 0; last_cnt = 0; last_pos = -1;
    for (int i = 0; i < out_d_q.size(); i++) begin
      if (out_d_q[i] !== 64'(base + i)) bad++;
      if (out_l_q[i]) begin
        last_cnt++;
        last_pos = i;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_valid = 1'b0; s_data = 16'd0; s_last = 1'b0; m_ready = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({s_ready, fir_en, m_valid, m_last, busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 00000", {s_ready, fir_en, m_valid, m_last, busy});
    end
    tests_run++;
    if ({frm_data_3, frm_data_2, frm_data_1} !== 48'd0) begin
      tests_failed++;
      $display("FAIL reset_frm: got %h required 0", {frm_data_3, frm_data_2, frm_data_1});
    end
    tests_run++;
    if (m_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_mdata: got %h required 0", m_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_sready_hold: got %b required 0", s_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_sready_rise: got %b required 1", s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream6();
    int bad, lc, lp;
    clear_mon(); ready_mode = 0;
    for (int i = 1; i <= 6; i++) push_src(16'(i), i == 6);
    run_until("stream6", 6, 500);
    tests_run++;
    if (frm_q.size() < 3 || frm_q[0] !== {16'd3, 16'd2, 16'd1} || frm_q[1] !== {16'd6, 16'd5, 16'd4} || frm_q[2] !== 48'd0) begin
      tests_failed++;
      $display("FAIL stream6_frames: got %0d frames first %h required 321 then 654 then zero", frm_q.size(), (frm_q.size() > 0) ? frm_q[0] : 48'd0);
    end
    scan_seq(1, bad, lc, lp);
    tests_run++;
    if (out_d_q.size() !== 6 || bad !== 0) begin
      tests_failed++;
      $display("FAIL stream6_data: got %0d outputs %0d wrong required 6 outputs 0 wrong", out_d_q.size(), bad);
    end
    tests_run++;
    if (lc !== 1 || lp !== 5) begin
      tests_failed++;
      $display("FAIL stream6_last: got count %0d at %0d required 1 at 5", lc, lp);
    end
    tests_run++;
    if (en_cnt !== 42) begin
      tests_failed++;
      $display("FAIL stream6_enables: got %0d required 42", en_cnt);
    end
  endtask

  task automatic test_last4();
    int bad, lc, lp;
    clear_mon(); ready_mode = 0;
    for (int i = 1; i <= 4; i++) push_src(16'(i), i == 4);
    run_until("last4", 4, 500);
    tests_run++;
    if (frm_q.size() < 2 || frm_q[1] !== {16'd0, 16'd0, 16'd4}) begin
      tests_failed++;
      $display("FAIL last4_frame: got %h required 000000000004", (frm_q.size() > 1) ? frm_q[1] : 48'hx);
    end
    scan_seq(1, bad, lc, lp);
    tests_run++;
    if (out_d_q.size() !== 4 || bad !== 0 || lc !== 1 || lp !== 3) begin
      tests_failed++;
      $display("FAIL last4_out: got %0d outputs %0d wrong last %0d at %0d required 4 0 1 3", out_d_q.size(), bad, lc, lp);
    end
    tests_run++;
    if (en_cnt !== 42) begin
      tests_failed++;
      $display("FAIL last4_enables: got %0d required 42 (2 frames + 40 flush)", en_cnt);
    end
    tests_run++;
    if (busy_seen !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL last4_busy: got seen %b final %b required seen 1 final 0", busy_seen, busy);
    end
  endtask

  task automatic test_backpressure();
    int bad, lc, lp;
    clear_mon(); ready_mode = 1;
    for (int i = 1; i <= 60; i++) push_src(16'(i), i == 60);
    run_cycles(200);
    tests_run++;
    if (en_cnt !== 17 || acc_cnt !== 54 || out_d_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL bp_stall: got enables %0d accepted %0d outputs %0d required 17 54 0", en_cnt, acc_cnt, out_d_q.size());
    end
    ready_mode = 0;
    run_until("bp", 60, 2000);
    scan_seq(1, bad, lc, lp);
    tests_run++;
    if (out_d_q.size() !== 60 || bad !== 0) begin
      tests_failed++;
      $display("FAIL bp_data: got %0d outputs %0d wrong required 60 outputs 0 wrong", out_d_q.size(), bad);
    end
    tests_run++;
    if (lc !== 1 || lp !== 59 || en_cnt !== 60) begin
      tests_failed++;
      $display("FAIL bp_tail: got last %0d at %0d enables %0d required 1 at 59 enables 60", lc, lp, en_cnt);
    end
  endtask

  task automatic test_toggle();
    logic [15:0] vin [7];
    logic [63:0] vexp [7];
    int bad, lc, lp;
    vin  = '{16'd10, 16'hFFFB, 16'd300, 16'h8000, 16'd7, 16'h7FFF, 16'd1};
    vexp = '{64'd10, 64'hFFFF_FFFF_FFFF_FFFB, 64'd300, 64'hFFFF_FFFF_FFFF_8000,
             64'd7, 64'h0000_0000_0000_7FFF, 64'd1};
    clear_mon(); ready_mode = 2;
    for (int i = 0; i < 7; i++) push_src(vin[i], i == 6);
    run_until("toggle", 7, 800);
    bad = 0; lc = 0; lp = -1;
    for (int i = 0; i < out_d_q.size() && i < 7; i++) begin
      if (out_d_q[i] !== vexp[i]) bad++;
      if (out_l_q[i]) begin
        lc++;
        lp = i;
      end
    end
    tests_run++;
    if (out_d_q.size() !== 7 || bad !== 0) begin
      tests_failed++;
      $display("FAIL toggle_data: got %0d outputs %0d wrong required 7 outputs 0 wrong", out_d_q.size(), bad);
    end
    tests_run++;
    if (stab_err !== 0 || lc !== 1 || lp !== 6) begin
      tests_failed++;
      $display("FAIL toggle_hold: got unstable %0d last %0d at %0d required 0 1 6", stab_err, lc, lp);
    end
  endtask

  task automatic test_reset_mid();
    int k, bad, lc, lp;
    clear_mon(); ready_mode = 0;
    push_src(16'd1, 1'b0); push_src(16'd2, 1'b0); push_src(16'd3, 1'b0);
    k = 0;
    while (acc_cnt < 2 && k < 20) begin
      step_cycle();
      k++;
    end
    reset_n = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({s_ready, fir_en, m_valid, m_last, busy} !== 5'b0 || {frm_data_3, frm_data_2, frm_data_1} !== 48'd0 || m_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got ctrl %b frm %h mdata %h required all zero", {s_ready, fir_en, m_valid, m_last, busy}, {frm_data_3, frm_data_2, frm_data_1}, m_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_mon();
    push_src(16'd7, 1'b0); push_src(16'd8, 1'b0); push_src(16'd9, 1'b1);
    run_until("midreset", 3, 500);
    tests_run++;
    if (frm_q.size() < 1 || frm_q[0] !== {16'd9, 16'd8, 16'd7}) begin
      tests_failed++;
      $display("FAIL midreset_lane1: got %h required 000900080007", (frm_q.size() > 0) ? frm_q[0] : 48'hx);
    end
    scan_seq(7, bad, lc, lp);
    tests_run++;
    if (out_d_q.size() !== 3 || bad !== 0 || lp !== 2) begin
      tests_failed++;
      $display("FAIL midreset_out: got %0d outputs %0d wrong last at %0d required 3 0 2", out_d_q.size(), bad, lp);
    end
  endtask

`ifdef FIR_SEQ_STATS_EN
  task automatic test_stats();
    reset_n = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_mon(); ready_mode = 0;
    for (int i = 1; i <= 9; i++) push_src(16'(i), i == 9);
    run_until("stats", 9, 500);
    tests_run++;
    if (stat_frames !== 32'd3 || stat_stalls !== 32'd0) begin
      tests_failed++;
      $display("FAIL stats: got frames %0d stalls %0d required 3 0", stat_frames, stat_stalls);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream6();
    test_last4();
    test_backpressure();
    test_toggle();
    test_reset_mid();
`ifdef FIR_SEQ_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fir_l3_frame_sequencer.md
# fir_l3_frame_sequencer

Stream-to-frame controller for the 3-parallel reduced-complexity FIR datapath. Accepts a serial valid/ready sample stream, packs samples into 3-lane frames, and drives the filter with a per-frame advance enable. Tags each frame through the filter pipeline, buffers result frames in an output FIFO, and re-serialises them with backpressure. Sits between the sample source and the parallel filter, with a zero-frame flush at end of burst.

## Interface
- DATA_IN_WIDTH, 16, sample width (signed)
- DATA_OUT_WIDTH, 64, filter result width (signed)
- PIPE_LATENCY, 8, filter enables from frame issue to matching result at fir_out_*; ≥1
- FLUSH_LEN, 40, zero frames issued after a last sample; ≥ PIPE_LATENCY + taps per sub-filter
- OUT_FIFO_DEPTH, 8, output FIFO depth in frames; power of two, ≥2
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- s_valid / s_ready  in / out  1  input handshake
- s_data  in  DATA_IN_WIDTH  input sample
- s_last  in  1  last sample of burst
- fir_en  out  1  filter advance enable (delay lines and pipeline registers step only when 1)
- frm_data_1/2/3  out  DATA_IN_WIDTH  frame lanes; lane 1 = oldest sample
- fir_out_1/2/3  in  DATA_OUT_WIDTH  filter result lanes
- m_valid / m_ready  out / in  1  output handshake
- m_data  out  DATA_OUT_WIDTH  output sample
- m_last  out  1  last real output of burst
- busy  out  1  high in FLUSH or while any tag/FIFO entry is non-empty

## Operation
- FSM states: FILL, ISSUE, FLUSH.
- FILL:
  - Accepts samples into lane index 0..2.
  - On the third accepted sample, or on s_last, goes to ISSUE with lane count 1..3.
  - Unfilled lanes are zero.
- ISSUE:
  - s_ready=0.
  - Waits for room (FIFO count < OUT_FIFO_DEPTH), then asserts fir_en for one cycle.
  - Returns to FILL, or to FLUSH if the frame carried s_last.
- FLUSH:
  - Issues FLUSH_LEN zero frames with lane count 0, each gated by room.
  - Returns to FILL after the last flush frame.
- Tag pipeline: PIPE_LATENCY entries of {lane count[1:0], last}, shifted only on fir_en.
  - On a fir_en cycle, the tail tag describes the current fir_out_*.
  - If the tail lane count > 0, {fir_out_*, tag} is written to the FIFO on that edge.
- Serialiser:
  - Pops one frame and emits lanes 1..count on m_data, one per m_valid&&m_ready.
  - m_last is asserted with the final lane of a frame whose tag has last=1.
- Lane-count-0 results are never written. Flush tail outputs are discarded.
- Room check is conservative: no same-cycle pop credit, so the FIFO never overflows.

## Timing
- Reset values: s_ready=0, fir_en=0, frm_data_*=0, m_valid=0, m_data=0, m_last=0, busy=0; FSM=FILL, lane index 0, tags and FIFO empty.
- s_ready rises in the first cycle after reset release.
- fir_en and frm_data_* are registered.
  - Third sample accepted at edge E: fir_en=1 in cycle E+1 if room.
  - Otherwise fir_en holds off until room exists; frame data holds stable meanwhile.
- Max input throughput: 3 samples per 4 cycles (FILL ×3, ISSUE ×1).
- Result of frame k reaches the FIFO at the edge of the PIPE_LATENCY-th fir_en after its issue. With no backpressure, its first m_valid follows one cycle later.
- s_last with lane index 0: the frame holds one sample, lane count 1.
- Reset mid-burst discards partial frame, tags and FIFO. The filter is reset by the same reset_n.
- m_data and m_last hold stable while m_valid=1 and m_ready=0.

## Configuration
- FIR_SEQ_STATS_EN defined: adds outputs stat_frames (32 bit, real frames issued) and stat_stalls (32 bit, cycles in ISSUE/FLUSH with fir_en blocked by room).
  - Both reset to 0 and wrap modulo 2^32.
- FIR_SEQ_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package fir_l3_pkg holds:
  - the state enum (FILL/ISSUE/FLUSH);
  - the tag struct {lane_cnt[1:0], last};
  - the lane count localparam (3).
- One sub-module: fir_l3_out_fifo, a synchronous FIFO of {3×DATA_OUT_WIDTH, tag} with count output.
- FSM, tag pipeline and serialiser live in the top.

## Test plan
- Samples 1..6 with s_valid held high and the filter modelled as identity with PIPE_LATENCY=8 → frames {1,2,3} and {4,5,6} on frm_data_*; m_data emits 1..6 in order after 8 enables each.
- 4 samples, s_last on 4th → second frame {4,0,0} with lane count 1; exactly 4 outputs; m_last on value 4; 40 flush enables; busy falls after last output.
- m_ready=0 for 200 cycles with continuous input, OUT_FIFO_DEPTH=8 → fir_en stops when the FIFO holds 8 frames; no output lost or duplicated after m_ready=1.
- m_ready toggling every cycle → m_data/m_last stable while stalled; order preserved.
- reset_n pulsed low mid-frame (after 2 samples) → all outputs at reset values; next accepted sample lands in lane 1.
- FIR_SEQ_STATS_EN defined, 9 samples with s_last, m_ready=1 → stat_frames=3, stat_stalls=0.
